// File: rtl/matrix_mult_unit.sv
// matrix_mult_unit: bus-attached 4x4 unsigned 16-bit matrix multiplier.
// It computes R = A x B one element per clock, and the engine polls STATUS.
module matrix_mult_unit #(
    parameter logic [3:0] BASE_NIB = 4'h3
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic [255:0] DataIn,
    output logic [255:0] DataOut,
    input  logic [15:0]  address,
    input  logic         nRead,
    input  logic         nWrite
);
    typedef enum logic {IDLE, CALC} stateType;
    stateType state;
    logic [15:0][15:0] matA, matB, matR;
    logic [3:0] idx;
    logic busy, done, err;
    logic sel, wrEn, rdEn;
    logic [1:0] off;
    logic [33:0] acc;
    logic [255:0] rdData;

    assign sel  = address[15:12] == BASE_NIB;
    assign wrEn = sel && !nWrite;
    assign rdEn = sel && !nRead && nWrite;
    assign off  = address[1:0];

    // Dot product of row idx[3:2] of A with column idx[1:0] of B; R keeps the low 16 bits
    always_comb begin
        acc = '0;
        for (int k = 0; k < 4; k++)
            acc = acc + {2'b0, {16'b0, matA[{idx[3:2], 2'(k)}]} * {16'b0, matB[{2'(k), idx[1:0]}]}};
    end

    always_comb begin
        rdData = !rdEn     ? '0 :
                 off == 0  ? matA :
                 off == 1  ? matB :
                 off == 2  ? matR : {253'b0, err, done, busy};
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            matA    <= '0;
            matB    <= '0;
            matR    <= '0;
            DataOut <= '0;
        end else begin
            DataOut <= rdData;
            if (state == CALC) begin
                matR[idx] <= acc[15:0];
                idx       <= idx + 4'd1;
                if (idx == 4'd15) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                // R is read-only, so only A, B and CMD writes count as collisions
                if (wrEn && off != 2'd2)
                    err <= 1'b1;
            end else if (wrEn) begin
                if (off == 2'd0)
                    matA <= DataIn;
                if (off == 2'd1)
                    matB <= DataIn;
                if (off == 2'd3 && DataIn[1:0] == 2'b01) begin
                    state <= CALC;
                    idx   <= '0;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                    matR  <= '0;
                end
                if (off == 2'd3 && DataIn[1:0] == 2'b10) begin
                    matA <= '0;
                    matB <= '0;
                    matR <= '0;
                    done <= 1'b0;
                    err  <= 1'b0;
                end
            end
        end
    end
endmodule
